sat_accum: RTL and testbench

Multi-channel saturating accumulator for the signed sample datapath. It sums a stream of signed DATA_WIDTH samples into one of CHANNELS independent ACC_WIDTH accumulators, clamping each update to the signed range instead of wrapping. On a frame's last beat it emits the clamped sum, beat count and saturation status, then clears that channel. It generalises the team's combinational saturating adder into a registered, handshaked, per-channel block that sits between the sample source and frame-level post-processing.

---
 rtl/sat_accum_pkg.sv | 17 +
 rtl/sat_add_ext.sv | 31 +++
 rtl/sat_accum.sv | 148 ++++++++++++++
 tb/tb_sat_accum.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sat_accum_pkg.sv
// Shared types and saturation bounds for the sat_accum block.
package sat_accum_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  function automatic logic signed [63:0] sat_max(input int unsigned width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int unsigned width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/sat_add_ext.sv
// Combinational signed saturating adder; clamp_o flags a clamped result.
module sat_add_ext #(
  parameter int WIDTH = 24
) (
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  output logic signed [WIDTH-1:0] result_o,
  output logic                    clamp_o
);
  import sat_accum_pkg::*;

  localparam logic signed [WIDTH:0] MAX_V = (WIDTH + 1)'(sat_max(WIDTH));
  localparam logic signed [WIDTH:0] MIN_V = (WIDTH + 1)'(sat_min(WIDTH));

  // One guard bit is enough to hold any sum of two WIDTH-bit operands.
  logic signed [WIDTH:0] sum;
  assign sum = {a_i[WIDTH-1], a_i} + {b_i[WIDTH-1], b_i};

  always_comb begin
    result_o = sum[WIDTH-1:0];
    clamp_o  = 1'b0;
    if (sum > MAX_V) begin
      result_o = MAX_V[WIDTH-1:0];
      clamp_o  = 1'b1;
    end else if (sum < MIN_V) begin
      result_o = MIN_V[WIDTH-1:0];
      clamp_o  = 1'b1;
    end
  end

endmodule

// File: rtl/sat_accum.sv
// Multi-channel saturating frame accumulator with a single-entry result skid.
// SAT_ACCUM_SAT_FLAG_EN enables the per-channel sticky clamp flags behind m_sat_o.
module sat_accum #(
  parameter  int DATA_WIDTH = 16,
  parameter  int ACC_WIDTH  = 24,
  parameter  int CHANNELS   = 4,
  parameter  int CNT_WIDTH  = 8,
  localparam int CH_WIDTH   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         s_valid_i,
  output logic                         s_ready_o,
  input  logic signed [DATA_WIDTH-1:0] s_data_i,
  input  logic        [CH_WIDTH-1:0]   s_ch_i,
  input  logic                         s_last_i,
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic signed [ACC_WIDTH-1:0]  m_data_o,
  output logic        [CH_WIDTH-1:0]   m_ch_o,
  output logic        [CNT_WIDTH-1:0]  m_cnt_o,
  output logic                         m_sat_o
);
  import sat_accum_pkg::*;

  logic signed [ACC_WIDTH-1:0] acc_q [CHANNELS];
  logic signed [ACC_WIDTH-1:0] acc_d [CHANNELS];
  logic        [CNT_WIDTH-1:0] cnt_q [CHANNELS];
  logic        [CNT_WIDTH-1:0] cnt_d [CHANNELS];

  out_state_e                  state_q, state_d;
  logic signed [ACC_WIDTH-1:0] m_data_q, m_data_d;
  logic        [CH_WIDTH-1:0]  m_ch_q, m_ch_d;
  logic        [CNT_WIDTH-1:0] m_cnt_q, m_cnt_d;

  logic                        ch_ok, upd, last_upd, clamp;
  logic        [CH_WIDTH-1:0]  sel;
  logic signed [ACC_WIDTH-1:0] data_ext, sum_sat;
  logic        [CNT_WIDTH-1:0] cnt_inc;

  assign s_ready_o = (state_q == EMPTY) || m_ready_i;
  assign ch_ok     = int'(s_ch_i) < CHANNELS;
  // Out-of-range channels are consumed but must never touch channel state.
  assign upd       = s_valid_i && s_ready_o && ch_ok;
  assign last_upd  = upd && s_last_i;
  assign sel       = ch_ok ? s_ch_i : '0;
  assign data_ext  = ACC_WIDTH'(s_data_i);
  assign cnt_inc   = (cnt_q[sel] == '1) ? cnt_q[sel] : cnt_q[sel] + CNT_WIDTH'(1);

  sat_add_ext #(
    .WIDTH (ACC_WIDTH)
  ) u_sat_add (
    .a_i      (acc_q[sel]),
    .b_i      (data_ext),
    .result_o (sum_sat),
    .clamp_o  (clamp)
  );

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (upd) begin
      if (s_last_i) begin
        acc_d[sel] = '0;
        cnt_d[sel] = '0;
      end else begin
        acc_d[sel] = sum_sat;
        cnt_d[sel] = cnt_inc;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    m_ch_d   = m_ch_q;
    m_cnt_d  = m_cnt_q;
    if (last_upd) begin
      state_d  = FULL;
      m_data_d = sum_sat;
      m_ch_d   = sel;
      m_cnt_d  = cnt_inc;
    end else if (m_ready_i) begin
      state_d  = EMPTY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      state_q  <= EMPTY;
      m_data_q <= '0;
      m_ch_q   <= '0;
      m_cnt_q  <= '0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      m_data_q <= m_data_d;
      m_ch_q   <= m_ch_d;
      m_cnt_q  <= m_cnt_d;
    end
  end

  assign m_valid_o = (state_q == FULL);
  assign m_data_o  = m_data_q;
  assign m_ch_o    = m_ch_q;
  assign m_cnt_o   = m_cnt_q;

`ifdef SAT_ACCUM_SAT_FLAG_EN
  logic [CHANNELS-1:0] sat_q, sat_d;
  logic                sat_cur;
  logic                m_sat_q, m_sat_d;

  assign sat_cur = sat_q[sel] | clamp;

  always_comb begin
    sat_d   = sat_q;
    m_sat_d = m_sat_q;
    if (upd) begin
      sat_d[sel] = s_last_i ? 1'b0 : sat_cur;
    end
    if (last_upd) begin
      m_sat_d = sat_cur;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sat_q   <= '0;
      m_sat_q <= 1'b0;
    end else begin
      sat_q   <= sat_d;
      m_sat_q <= m_sat_d;
    end
  end

  assign m_sat_o = m_sat_q;
`else
  logic unused_clamp;
  assign unused_clamp = clamp;
  assign m_sat_o      = 1'b0;
`endif

endmodule

// File: tb/tb_sat_accum.sv
// Randomised and directed self-checking bench for sat_accum against a frame-level model.
module tb_sat_accum;

  localparam int DW  = 16;
  localparam int AW  = 24;
  localparam int CH  = 4;
  localparam int CW  = 8;
  localparam int CHW = 2;
  localparam longint MAXV   = (64'sd1 <<< (AW - 1)) - 1;
  localparam longint MINV   = -(64'sd1 <<< (AW - 1));
  localparam int     CNTMAX = (1 << CW) - 1;
`ifdef SAT_ACCUM_SAT_FLAG_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic                  s_valid_i;
  logic                  s_ready_o;
  logic signed [DW-1:0]  s_data_i;
  logic [CHW-1:0]        s_ch_i;
  logic                  s_last_i;
  logic                  m_valid_o;
  logic                  m_ready_i;
  logic signed [AW-1:0]  m_data_o;
  logic [CHW-1:0]        m_ch_o;
  logic [CW-1:0]         m_cnt_o;
  logic                  m_sat_o;

  sat_accum #(
    .DATA_WIDTH (DW),
    .ACC_WIDTH  (AW),
    .CHANNELS   (CH),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .s_data_i  (s_data_i),
    .s_ch_i    (s_ch_i),
    .s_last_i  (s_last_i),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_data_o  (m_data_o),
    .m_ch_o    (m_ch_o),
    .m_cnt_o   (m_cnt_o),
    .m_sat_o   (m_sat_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Frame-level model: running sums per channel plus the one pending result.
  longint m_acc [CH];
  int     m_cnt [CH];
  bit     m_sat [CH];
  bit     e_vld;
  longint e_data;
  int     e_ch;
  int     e_cnt;
  bit     e_sat;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < CH; i++) begin
      m_acc[i] = 0;
      m_cnt[i] = 0;
      m_sat[i] = 1'b0;
    end
    e_vld = 1'b0;
  endtask

  task automatic check_out();
    check("m_valid", longint'(m_valid_o), longint'(e_vld));
    if (e_vld) begin
      check("m_data", longint'($signed(m_data_o)), e_data);
      check("m_ch",   longint'(m_ch_o), longint'(e_ch));
      check("m_cnt",  longint'(m_cnt_o), longint'(e_cnt));
      check("m_sat",  longint'(m_sat_o), longint'(e_sat));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_s_ready"}, longint'(s_ready_o), 1);
    check({tag, "_m_valid"}, longint'(m_valid_o), 0);
    check({tag, "_m_data"},  longint'($signed(m_data_o)), 0);
    check({tag, "_m_ch"},    longint'(m_ch_o), 0);
    check({tag, "_m_cnt"},   longint'(m_cnt_o), 0);
    check({tag, "_m_sat"},   longint'(m_sat_o), 0);
  endtask

  task automatic expect_result(input string tag, input longint data, input int ch,
                               input int cnt, input bit sat);
    check({tag, "_valid"}, longint'(m_valid_o), 1);
    check({tag, "_data"},  longint'($signed(m_data_o)), data);
    check({tag, "_ch"},    longint'(m_ch_o), longint'(ch));
    check({tag, "_cnt"},   longint'(m_cnt_o), longint'(cnt));
    check({tag, "_sat"},   longint'(m_sat_o), longint'(sat));
  endtask

  // One clock: drive after a falling edge, check s_ready, clock, update model, check outputs.
  task automatic step(input bit v, input int ch, input longint d, input bit last, input bit rdy);
    bit     accepted;
    longint sum;
    bit     clamp;
    int     nc;
    s_valid_i = v;
    s_ch_i    = CHW'(ch);
    s_data_i  = DW'(d);
    s_last_i  = last;
    m_ready_i = rdy;
    #1;
    check("s_ready", longint'(s_ready_o), longint'(!e_vld || rdy));
    @(posedge clk_i);
    accepted = v && (!e_vld || rdy);
    if (e_vld && rdy) e_vld = 1'b0;
    if (accepted && ch < CH) begin
      sum   = m_acc[ch] + d;
      clamp = 1'b0;
      if (sum > MAXV) begin sum = MAXV; clamp = 1'b1; end
      if (sum < MINV) begin sum = MINV; clamp = 1'b1; end
      nc = (m_cnt[ch] + 1 > CNTMAX) ? CNTMAX : m_cnt[ch] + 1;
      if (last) begin
        e_vld     = 1'b1;
        e_data    = sum;
        e_ch      = ch;
        e_cnt     = nc;
        e_sat     = SAT_EN && (m_sat[ch] || clamp);
        m_acc[ch] = 0;
        m_cnt[ch] = 0;
        m_sat[ch] = 1'b0;
      end else begin
        m_acc[ch] = sum;
        m_cnt[ch] = nc;
        m_sat[ch] = m_sat[ch] || clamp;
      end
    end
    #1;
    check_out();
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni    = 1'b0;
    s_valid_i = 1'b0;
    s_data_i  = '0;
    s_ch_i    = '0;
    s_last_i  = 1'b0;
    m_ready_i = 1'b0;
    model_clear();
    #1;
    check_zero("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    step(1, 0, 100, 0, 1);
    step(1, 0, -30, 0, 1);
    step(1, 0, 7, 1, 1);
    expect_result("simple", 77, 0, 3, 1'b0);

    for (int i = 0; i < 300; i++) step(1, 1, 32767, i == 299, 1);
    expect_result("pos_clamp", MAXV, 1, CNTMAX, SAT_EN);

    // 257 beats push past the minimum so the clamp actually fires.
    for (int i = 0; i < 257; i++) step(1, 2, -32768, 0, 1);
    step(1, 2, 1000, 1, 1);
    expect_result("neg_recover", -8387608, 2, CNTMAX, SAT_EN);

    step(1, 1, 10, 0, 1);
    step(1, 2, 20, 0, 1);
    step(1, 1, 5, 1, 1);
    expect_result("ilv_a", 15, 1, 2, 1'b0);
    step(1, 2, -25, 1, 1);
    expect_result("ilv_b", -5, 2, 2, 1'b0);
    step(0, 0, 0, 0, 1);

    step(1, 0, 42, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0);
      check("bp_s_ready", longint'(s_ready_o), 0);
      expect_result("bp_hold", 42, 0, 1, 1'b0);
    end
    step(1, 3, 9, 1, 1);
    expect_result("bp_next", 9, 3, 1, 1'b0);
    step(0, 0, 0, 0, 1);

    step(1, 3, 500, 0, 1);
    step(1, 0, 11, 1, 0);
    #2;
    rst_ni = 1'b0;
    #1;
    s_valid_i = 1'b0;
    m_ready_i = 1'b0;
    check_zero("mid_reset");
    model_clear();
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(1, 3, 1, 1, 1);
    expect_result("after_reset", 1, 3, 1, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      longint d;
      if ($urandom_range(0, 3) == 0)
        d = ($urandom_range(0, 1) == 0) ? 32767 : -32768;
      else
        d = longint'($urandom_range(0, 65535)) - 32768;
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, CH - 1)), d,
           $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
    end
    step(0, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
